imm_extend_stage: RTL and testbench

Parametrised immediate-extension pipeline stage for the decode/execute boundary. Each accepted immediate is widened from `IN_W` to `OUT_W` bits in one of several per-transaction modes: sign, zero, upper-half (LUI) or, optionally, word-aligned branch offset. The stage is registered and uses a valid/ready handshake with a one-entry skid buffer, so the execute stage can stall without losing immediates. A flush input discards in-flight entries on branch mispredict.

---
 rtl/imm_ext_pkg.sv | 11 +
 rtl/imm_ext_skid.sv | 62 ++++++
 rtl/imm_extend_stage.sv | 60 ++++++
 tb/tb_imm_extend_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared mode encoding for the immediate-extension stage.
package imm_ext_pkg;
    localparam int IMM_MODE_W = 2;

    typedef enum logic [IMM_MODE_W-1:0] {
        IMM_SIGN   = 2'd0,
        IMM_ZERO   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_t;
endpackage

// File: rtl/imm_ext_skid.sv
// imm_ext_skid: two-entry (main + skid) valid/ready buffer with synchronous flush.
module imm_ext_skid #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);
    logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic         accept, emit;

    assign ready_o = !skid_valid_q;
    assign valid_o = main_valid_q;
    assign data_o  = main_data_q;

    always_comb begin
        accept       = valid_i && ready_o;
        emit         = main_valid_q && ready_i;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        // skid full implies ready_o low, so no accept can collide with the refill
        if (emit && skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (accept && (!main_valid_q || emit)) begin
            main_valid_d = 1'b1;
            main_data_d  = data_i;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = data_i;
        end else if (emit) begin
            main_valid_d = 1'b0;
        end
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end
endmodule

// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered immediate extension (sign/zero/upper/branch) behind a skid buffer.
// Define IMM_EXT_BRANCH_EN to build the branch-offset mode; otherwise mode 3 flags out_err.
module imm_extend_stage
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_imm,
    input  logic [IMM_MODE_W-1:0] in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_err
);
    localparam int EXT_W = OUT_W - IN_W;

    imm_mode_t        mode;
    logic [OUT_W-1:0] sign_ext, zero_ext, upper_ext, branch_ext, ext_data;
    logic             ext_err;
    logic [OUT_W:0]   held;

    always_comb begin
        mode      = imm_mode_t'(in_mode);
        sign_ext  = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
        zero_ext  = {{EXT_W{1'b0}}, in_imm};
        upper_ext = {in_imm, {EXT_W{1'b0}}};
        ext_data  = mode == IMM_SIGN  ? sign_ext  :
                    mode == IMM_ZERO  ? zero_ext  :
                    mode == IMM_UPPER ? upper_ext : branch_ext;
    end

`ifdef IMM_EXT_BRANCH_EN
    assign branch_ext = {sign_ext[OUT_W-3:0], 2'b00};
    assign ext_err    = 1'b0;
`else
    assign branch_ext = '0;
    assign ext_err    = mode == IMM_BRANCH;
`endif

    imm_ext_skid #(.W(OUT_W + 1)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .valid_i (in_valid),
        .ready_o (in_ready),
        .data_i  ({ext_err, ext_data}),
        .valid_o (out_valid),
        .ready_i (out_ready),
        .data_o  (held)
    );

    assign out_err  = held[OUT_W];
    assign out_data = held[OUT_W-1:0];
endmodule

// File: tb/tb_imm_extend_stage.sv
// tb_imm_extend_stage: directed vectors with a queue scoreboard checked on the falling edge.
module tb_imm_extend_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_err;

    logic [32:0] exp_cur = '0;
    logic [32:0] sb[$];
    int          checks = 0;
    int          failures = 0;

    imm_extend_stage #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor pops on every emit; accepts push what the stimulus declared as expected.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_output", {31'd0, out_err, out_data}, 64'hDEAD);
                else chk("scoreboard", {31'd0, out_err, out_data}, {31'd0, sb.pop_front()});
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(exp_cur);
        end
    end

    task automatic put(input logic [15:0] imm, input logic [1:0] mode, input logic [32:0] exp);
        bit acc;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        exp_cur  = exp;
        acc      = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("put_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        put(16'h8001, 2'd0, {1'b0, 32'hFFFF8001});
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("latency_data", 64'(out_data), 64'hFFFF8001);
        put(16'h8001, 2'd1, {1'b0, 32'h00008001});
        put(16'h1234, 2'd2, {1'b0, 32'h12340000});
`ifdef IMM_EXT_BRANCH_EN
        put(16'hFFFF, 2'd3, {1'b0, 32'hFFFFFFFC});
        put(16'h0004, 2'd3, {1'b0, 32'h00000010});
`else
        put(16'h0001, 2'd3, {1'b1, 32'h00000000});
        chk("illegal_err", 64'(out_err), 64'd1);
        chk("illegal_data", 64'(out_data), 64'd0);
`endif
        put(16'h0005, 2'd0, {1'b0, 32'h00000005});
        chk("after_err_clear", 64'(out_err), 64'd0);
        drain();

        // Stall: A loads, then downstream stops; B fills skid, C must wait.
        put(16'h00AA, 2'd1, {1'b0, 32'h000000AA});
        out_ready = 1'b0;
        put(16'h00BB, 2'd1, {1'b0, 32'h000000BB});
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_imm   = 16'h00CC;
        in_mode  = 2'd1;
        exp_cur  = {1'b0, 32'h000000CC};
        repeat (3) @(posedge clk);
        #1;
        chk("stall_hold_ready", 64'(in_ready), 64'd0);
        chk("stall_hold_data", 64'(out_data), 64'h000000AA);
        out_ready = 1'b1;
        put(16'h00CC, 2'd1, {1'b0, 32'h000000CC});
        drain();

        // Flush with both entries full while upstream offers an item.
        out_ready = 1'b0;
        put(16'h000D, 2'd1, {1'b0, 32'h0000000D});
        put(16'h000E, 2'd1, {1'b0, 32'h0000000E});
        in_valid = 1'b1;
        in_imm   = 16'h00F0;
        exp_cur  = {1'b0, 32'h000000F0};
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_full_valid", 64'(out_valid), 64'd0);
        chk("flush_full_ready", 64'(in_ready), 64'd1);

        // Flush dominating a real accept: the offered item must vanish.
        put(16'h0011, 2'd1, {1'b0, 32'h00000011});
        in_valid = 1'b1;
        in_imm   = 16'h00F1;
        exp_cur  = {1'b0, 32'h000000F1};
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_acc_valid", 64'(out_valid), 64'd0);
        chk("flush_acc_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        put(16'h0022, 2'd1, {1'b0, 32'h00000022});
        drain();

        // Asynchronous reset with both entries full.
        out_ready = 1'b0;
        put(16'h1111, 2'd1, {1'b0, 32'h00001111});
        put(16'h2222, 2'd1, {1'b0, 32'h00002222});
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        put(16'h7FFF, 2'd0, {1'b0, 32'h00007FFF});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
